// File: rtl/irq_queue_ctrl.sv
// Interrupt capture and queueing controller.
// Captures per-channel interrupt events (edge or level), holds them as pending,
// and feeds a small FIFO of interrupt IDs in round-robin order, with at most one
// queued entry per channel and a sticky flag for lost events.
module irq_queue_ctrl #(
    parameter int unsigned NCH   = 7,
    parameter int unsigned IDW   = 3,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3,
    parameter int unsigned EDGE  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] irq_in,
    input  logic [NCH-1:0] mask,
    input  logic           ack,
    input  logic           clr_ovf,
    output logic           irq_valid,
    output logic [IDW-1:0] irq_id,
    output logic [CW-1:0]  count,
    output logic           overflow
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned QW = $clog2(DEPTH);

    logic [NCH-1:0] prev;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] inq;
    logic [PW-1:0]  rr_ptr;
    logic [QW-1:0]  rd_ptr;
    logic [QW-1:0]  wr_ptr;
    logic [IDW-1:0] queue [DEPTH];

    logic [NCH-1:0] ev_m;
    logic           sel_found;
    logic [PW-1:0]  sel_idx;
    logic           do_pop;
    logic           do_push;
    logic [IDW-1:0] push_id;
    logic [NCH-1:0] push_oh;
    logic [NCH-1:0] pop_oh;
    logic [NCH-1:0] pending_next;
    logic [NCH-1:0] inq_next;
    logic [PW-1:0]  rr_next;
    logic [QW-1:0]  rd_next;
    logic [QW-1:0]  wr_next;
    logic [CW-1:0]  count_next;
    logic [IDW-1:0] head_next;
    logic           ovf_set;

    // Channel reached by stepping k places upward from base, modulo NCH.
    function automatic logic [PW-1:0] ch_at(input logic [PW-1:0] base, input int unsigned k);
        int unsigned s;
        s = (32'(base) + k) % NCH;
        return PW'(s);
    endfunction

    // Queue pointer increment with explicit wrap for non power-of-2 depths.
    function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
        return (p == QW'(DEPTH - 1)) ? '0 : p + QW'(1);
    endfunction

    // Qualified events: rising edge or level, gated by the channel mask.
    always_comb begin
        ev_m = '0;
        if (EDGE != 0) begin
            ev_m = irq_in & ~prev & mask;
        end else begin
            ev_m = irq_in & mask;
        end
    end

    // Round-robin scan for the first pending channel not already queued.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!sel_found && pending[ch_at(rr_ptr, k)] && !inq[ch_at(rr_ptr, k)]) begin
                sel_found = 1'b1;
                sel_idx   = ch_at(rr_ptr, k);
            end
        end
    end

    // Push/pop decisions and next-state of all queue bookkeeping.
    always_comb begin
        do_pop     = ack && (count != '0);
        do_push    = sel_found && ((count < CW'(DEPTH)) || do_pop);
        push_id    = IDW'(sel_idx) + IDW'(1);
        push_oh    = '0;
        pop_oh     = '0;
        rr_next    = rr_ptr;
        rd_next    = rd_ptr;
        wr_next    = wr_ptr;
        count_next = count;
        head_next  = '0;

        if (do_push) begin
            push_oh = NCH'(1) << sel_idx;
            rr_next = (sel_idx == PW'(NCH - 1)) ? '0 : sel_idx + PW'(1);
            wr_next = q_inc(wr_ptr);
        end
        // Current head ID identifies the channel being released.
        for (int unsigned i = 0; i < NCH; i++) begin
            pop_oh[i] = do_pop && (irq_id == IDW'(i + 1));
        end
        if (do_pop) begin
            rd_next = q_inc(rd_ptr);
        end

        unique case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase

        // Head after this edge: freshly pushed entry if it lands at the new head.
        if (count_next != '0) begin
            if (do_push && (wr_ptr == rd_next)) begin
                head_next = push_id;
            end else begin
                head_next = queue[rd_next];
            end
        end

        // New events win over the clear from a same-cycle push.
        pending_next = (pending & ~push_oh) | ev_m;
        inq_next     = (inq & ~pop_oh) | push_oh;
        ovf_set      = |(ev_m & pending & ~push_oh);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev      <= '0;
            pending   <= '0;
            inq       <= '0;
            rr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else begin
            prev      <= irq_in;
            pending   <= pending_next;
            inq       <= inq_next;
            rr_ptr    <= rr_next;
            rd_ptr    <= rd_next;
            wr_ptr    <= wr_next;
            count     <= count_next;
            irq_valid <= (count_next != '0);
            irq_id    <= head_next;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // ID storage; contents are meaningless while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push) begin
            queue[wr_ptr] <= push_id;
        end
    end

endmodule

// File: tb/tb_irq_queue_ctrl.sv
// Directed bench for irq_queue_ctrl: an edge-mode instance and a level-mode instance.
module tb_irq_queue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] irq_a, mask_a, irq_b, mask_b;
    logic       ack_a, clr_a, ack_b, clr_b;
    logic       valid_a, valid_b, ovf_a, ovf_b;
    logic [2:0] id_a, id_b, cnt_a, cnt_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    irq_queue_ctrl #(.NCH(7), .IDW(3), .DEPTH(4), .CW(3), .EDGE(1)) dut_a (
        .clk(clk), .rst(rst), .irq_in(irq_a), .mask(mask_a), .ack(ack_a), .clr_ovf(clr_a),
        .irq_valid(valid_a), .irq_id(id_a), .count(cnt_a), .overflow(ovf_a)
    );

    irq_queue_ctrl #(.NCH(7), .IDW(3), .DEPTH(4), .CW(3), .EDGE(0)) dut_b (
        .clk(clk), .rst(rst), .irq_in(irq_b), .mask(mask_b), .ack(ack_b), .clr_ovf(clr_b),
        .irq_valid(valid_b), .irq_id(id_b), .count(cnt_b), .overflow(ovf_b)
    );

    typedef struct {
        logic       dut;
        logic [6:0] irq;
        logic [6:0] mask;
        logic       ack;
        logic       clr;
        logic       valid;
        logic [2:0] id;
        logic [2:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(int d, int irq, int msk, int ak, int cl, int v, int id, int cn, int ov);
        vec_t t;
        t.dut = 1'(d); t.irq = 7'(irq); t.mask = 7'(msk); t.ack = 1'(ak); t.clr = 1'(cl);
        t.valid = 1'(v); t.id = 3'(id); t.cnt = 3'(cn); t.ovf = 1'(ov);
        return t;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input int v, input int id, input int cn, input int ov);
        check({tag, " valid"}, 8'(valid_a), 8'(v));
        check({tag, " id"}, 8'(id_a), 8'(id));
        check({tag, " count"}, 8'(cnt_a), 8'(cn));
        check({tag, " ovf"}, 8'(ovf_a), 8'(ov));
    endtask

    task automatic run_vec(input vec_t t, input int n);
        if (t.dut == 1'b0) begin
            irq_a = t.irq; mask_a = t.mask; ack_a = t.ack; clr_a = t.clr;
        end else begin
            irq_b = t.irq; mask_b = t.mask; ack_b = t.ack; clr_b = t.clr;
        end
        @(posedge clk);
        #1;
        if (t.dut == 1'b0) begin
            check_a($sformatf("a%0d", n), int'(t.valid), int'(t.id), int'(t.cnt), int'(t.ovf));
        end else begin
            check($sformatf("b%0d valid", n), 8'(valid_b), 8'(t.valid));
            check($sformatf("b%0d id", n), 8'(id_b), 8'(t.id));
            check($sformatf("b%0d count", n), 8'(cnt_b), 8'(t.cnt));
            check($sformatf("b%0d ovf", n), 8'(ovf_b), 8'(t.ovf));
        end
    endtask

    task automatic idle_a(input string tag, input int v, input int id, input int cn);
        @(posedge clk);
        #1;
        check_a(tag, v, id, cn, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        irq_a = '0; mask_a = 7'h7F; ack_a = 1'b0; clr_a = 1'b0;
        irq_b = '0; mask_b = 7'h7F; ack_b = 1'b0; clr_b = 1'b0;

        // Edge mode: single pulse, round-robin order, full queue, dedup, overflow.
        tv.push_back(mk(0, 'h04, 'h7F, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 0, 0, 1, 3, 1, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 1, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 1, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 'h08, 'h7F, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 0, 0, 1, 4, 1, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 1, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 'h49, 'h7F, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 'h49, 'h7F, 0, 0, 1, 7, 1, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 0, 0, 1, 7, 2, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 0, 0, 1, 7, 3, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 1, 0, 1, 1, 2, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 1, 0, 1, 4, 1, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 1, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 'h40, 'h7F, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 0, 0, 1, 7, 1, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 1, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 'h7F, 'h7F, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 0, 0, 1, 1, 1, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 0, 0, 1, 1, 2, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 0, 0, 1, 1, 3, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 0, 0, 1, 1, 4, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 0, 0, 1, 1, 4, 0));
        tv.push_back(mk(0, 'h02, 'h7F, 0, 0, 1, 1, 4, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 1, 0, 1, 2, 4, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 0, 0, 1, 2, 4, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 1, 0, 1, 3, 4, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 1, 0, 1, 4, 4, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 1, 0, 1, 5, 4, 0));
        tv.push_back(mk(0, 'h20, 'h7F, 0, 0, 1, 5, 4, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 0, 0, 1, 5, 4, 0));
        tv.push_back(mk(0, 'h20, 'h7F, 0, 0, 1, 5, 4, 1));
        tv.push_back(mk(0, 'h00, 'h7F, 0, 0, 1, 5, 4, 1));
        tv.push_back(mk(0, 'h20, 'h7F, 0, 1, 1, 5, 4, 1));
        tv.push_back(mk(0, 'h00, 'h7F, 0, 1, 1, 5, 4, 0));
        tv.push_back(mk(0, 'h00, 'h7F, 1, 0, 1, 6, 3, 0));
        tv.push_back(mk(0, 'h20, 'h7F, 0, 0, 1, 6, 3, 1));
        tv.push_back(mk(0, 'h00, 'h7F, 0, 0, 1, 6, 3, 1));

        // Level mode: masked line ignored, then re-pushed after every ack.
        tv.push_back(mk(1, 'h02, 'h7D, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 'h02, 'h7D, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 'h02, 'h7F, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 'h02, 'h7F, 0, 0, 1, 2, 1, 0));
        tv.push_back(mk(1, 'h02, 'h7F, 0, 0, 1, 2, 1, 1));
        tv.push_back(mk(1, 'h02, 'h7F, 1, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, 'h02, 'h7F, 0, 0, 1, 2, 1, 1));
        tv.push_back(mk(1, 'h02, 'h7F, 1, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, 'h02, 'h7F, 0, 0, 1, 2, 1, 1));
        tv.push_back(mk(1, 'h00, 'h7F, 1, 1, 0, 0, 0, 0));
        tv.push_back(mk(1, 'h00, 'h7F, 0, 0, 1, 2, 1, 0));
        tv.push_back(mk(1, 'h00, 'h7F, 1, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 'h00, 'h7F, 0, 0, 0, 0, 0, 0));

        // Reset state, checked while reset is held.
        #12;
        check_a("reset", 0, 0, 0, 0);
        check("reset b count", 8'(cnt_b), 8'd0);
        rst = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].dut == 1'b0) run_vec(tv[i], i);
        end
        irq_a = '0; ack_a = 1'b0; clr_a = 1'b0;

        // Mid-operation reset with count=3 and overflow set: clears without a clock edge.
        #1;
        rst = 1'b0;
        #1;
        check_a("async reset", 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) idle_a($sformatf("post reset %0d", i), 0, 0, 0);

        // Line already high at reset release yields exactly one event.
        @(negedge clk);
        rst = 1'b0;
        irq_a = 7'h04;
        @(negedge clk);
        rst = 1'b1;
        idle_a("held high e1", 0, 0, 0);
        idle_a("held high e2", 1, 3, 1);
        idle_a("held high e3", 1, 3, 1);
        ack_a = 1'b1;
        idle_a("held high ack", 0, 0, 0);
        ack_a = 1'b0;
        idle_a("held high idle0", 0, 0, 0);
        idle_a("held high idle1", 0, 0, 0);
        irq_a = '0;

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].dut == 1'b1) run_vec(tv[i], i);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
